// File: rtl/cache_pkg.sv
// cache_pkg: shared op/state encodings, default widths and the width helper for the cache set.
package cache_pkg;
  typedef enum logic [1:0] {ACC_RD = 2'b00, ACC_WR = 2'b01, CMP_RD = 2'b10, CMP_WR = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RESP, FLUSH} state_e;
  localparam int DEF_WAYS   = 2;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAG_W  = 5;
  function automatic int clog2_min1(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/set_lru.sv
// set_lru: true-age LRU for one set; ages stay a permutation of 0..WAYS-1.
module set_lru import cache_pkg::*; #(
  parameter int WAYS  = DEF_WAYS,
  parameter int WAY_W = clog2_min1(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch_i,
  input  logic [WAY_W-1:0] touch_way_i,
  input  logic             restore_i,
  input  logic [WAYS-1:0]  valid_i,
  output logic [WAY_W-1:0] victim_o
);
  logic [WAY_W-1:0] age_q [WAYS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || restore_i) begin
      for (int i = 0; i < WAYS; i++) age_q[i] <= WAY_W'(i);
    end else if (touch_i) begin
      for (int i = 0; i < WAYS; i++)
        age_q[i] <= (WAY_W'(i) == touch_way_i) ? '0 :
                    (age_q[i] < age_q[touch_way_i]) ? age_q[i] + 1'b1 : age_q[i];
    end
  end
  // Oldest way first, then any invalid way overrides with the lowest index winning.
  always_comb begin
    victim_o = '0;
    for (int i = WAYS - 1; i >= 0; i--) if (age_q[i] == WAY_W'(WAYS - 1)) victim_o = WAY_W'(i);
    for (int i = WAYS - 1; i >= 0; i--) if (!valid_i[i]) victim_o = WAY_W'(i);
  end
endmodule

// File: rtl/assoc_set.sv
// assoc_set: one index of an N-way set-associative cache with compare/access ops,
// LRU victim selection and a one-way-per-cycle flush behind a req/ack handshake.
module assoc_set import cache_pkg::*; #(
  parameter int WAYS   = DEF_WAYS,
  parameter int WORDS  = DEF_WORDS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W,
  localparam int WAY_W = clog2_min1(WAYS),
  localparam int OFF_W = clog2_min1(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              comp,
  input  logic              write,
  input  logic [WAY_W-1:0]  way_sel,
  input  logic [OFF_W-1:0]  word,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              flush,
  output logic              ack,
  output logic              busy,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic [WAY_W-1:0]  victim_way,
  output logic [TAG_W-1:0]  tag_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              dirty_out
);
  state_e            state_q;
  logic [WAY_W-1:0]  f_q;
  logic [WAYS-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_q [WAYS];
  logic [DATA_W-1:0] data_q [WAYS][WORDS];
  logic              ack_q, hit_q, valid_out_q, dirty_out_q;
  logic [WAY_W-1:0]  hit_way_q, victim_q;
  logic [TAG_W-1:0]  tag_out_q;
  logic [DATA_W-1:0] data_out_q;
  op_e               op;
  logic              accept, hit_c, cmp_hit, acc_wr, cmp_wr_hit, touch, restore;
  logic [WAY_W-1:0]  hit_w, victim, rep_w;
  assign op         = op_e'({comp, write});
  assign accept     = (state_q == IDLE) && req && !flush;
  assign cmp_hit    = comp && hit_c;
  assign acc_wr     = op == ACC_WR;
  assign cmp_wr_hit = op == CMP_WR && hit_c;
  assign rep_w      = !comp ? way_sel : hit_c ? hit_w : victim;
  assign touch      = accept && (cmp_hit || acc_wr);
  assign restore    = (state_q == FLUSH) && (f_q == WAY_W'(WAYS - 1));
  always_comb begin
    hit_c = 1'b0;
    hit_w = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (valid_q[i] && tag_q[i] == tag_in) begin
        hit_c = 1'b1;
        hit_w = WAY_W'(i);
      end
  end
  set_lru #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
    .clk         (clk),
    .rst_n       (rst_n),
    .touch_i     (touch),
    .touch_way_i (comp ? hit_w : way_sel),
    .restore_i   (restore),
    .valid_i     (valid_q),
    .victim_o    (victim)
  );
  // Tags and data carry no reset; valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (accept && acc_wr) begin
      tag_q[way_sel]        <= tag_in;
      data_q[way_sel][word] <= data_in;
    end else if (accept && cmp_wr_hit) begin
      data_q[hit_w][word] <= data_in;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      f_q         <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      ack_q       <= 1'b0;
      hit_q       <= 1'b0;
      hit_way_q   <= '0;
      victim_q    <= '0;
      tag_out_q   <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      dirty_out_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (state_q == IDLE && flush) begin
        state_q <= FLUSH;
        f_q     <= '0;
      end else if (accept) begin
        state_q     <= RESP;
        ack_q       <= 1'b1;
        victim_q    <= victim;
        hit_q       <= cmp_hit;
        hit_way_q   <= cmp_hit ? hit_w : '0;
        tag_out_q   <= acc_wr ? tag_in : tag_q[rep_w];
        data_out_q  <= acc_wr ? data_in : data_q[rep_w][word];
        valid_out_q <= acc_wr ? valid_in : valid_q[rep_w];
        dirty_out_q <= (acc_wr || cmp_wr_hit) ? 1'b0 : dirty_q[rep_w];
        if (acc_wr) begin
          valid_q[way_sel] <= valid_in;
          dirty_q[way_sel] <= 1'b0;
        end
        if (cmp_wr_hit) dirty_q[hit_w] <= 1'b1;
      end else if (state_q == RESP) begin
        state_q <= IDLE;
      end else if (state_q == FLUSH) begin
        // Ack rides on the final flush cycle so the whole flush spans exactly WAYS cycles.
        valid_q[f_q] <= 1'b0;
        dirty_q[f_q] <= 1'b0;
        f_q          <= f_q + 1'b1;
        ack_q        <= f_q == WAY_W'(WAYS - 2);
        state_q      <= restore ? IDLE : FLUSH;
      end
    end
  end
  assign ack        = ack_q;
  assign busy       = state_q != IDLE;
  assign hit        = hit_q;
  assign hit_way    = hit_way_q;
  assign victim_way = victim_q;
  assign tag_out    = tag_out_q;
  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign dirty_out  = dirty_out_q;
endmodule

// File: tb/tb_assoc_set.sv
// tb_assoc_set: directed ops with hand-computed responses queued into a scoreboard checked on ack.
module tb_assoc_set;
  logic        clk = 1'b0;
  logic        rst_n, req, comp, write, valid_in, flush;
  logic [0:0]  way_sel;
  logic [1:0]  word;
  logic [4:0]  tag_in;
  logic [15:0] data_in;
  logic        ack, busy, hit, valid_out, dirty_out;
  logic [0:0]  hit_way, victim_way;
  logic [4:0]  tag_out;
  logic [15:0] data_out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       name;
    logic        fl;
    logic        hit;
    logic [0:0]  hw;
    logic [0:0]  vic;
    logic [4:0]  tag;
    logic [15:0] data;
    logic        vld;
    logic        dty;
    logic        ct;
    logic        cd;
  } exp_t;
  exp_t q[$];
  assoc_set dut (
    .clk(clk), .rst_n(rst_n), .req(req), .comp(comp), .write(write), .way_sel(way_sel),
    .word(word), .tag_in(tag_in), .data_in(data_in), .valid_in(valid_in), .flush(flush),
    .ack(ack), .busy(busy), .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
    .tag_out(tag_out), .data_out(data_out), .valid_out(valid_out), .dirty_out(dirty_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (ack) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.fl) chk({e.name, ".busy"}, 32'(busy), 32'd1);
        else begin
          chk({e.name, ".hit"}, 32'(hit), 32'(e.hit));
          chk({e.name, ".hit_way"}, 32'(hit_way), 32'(e.hw));
          chk({e.name, ".victim"}, 32'(victim_way), 32'(e.vic));
          chk({e.name, ".valid"}, 32'(valid_out), 32'(e.vld));
          chk({e.name, ".dirty"}, 32'(dirty_out), 32'(e.dty));
          if (e.ct) chk({e.name, ".tag"}, 32'(tag_out), 32'(e.tag));
          if (e.cd) chk({e.name, ".data"}, 32'(data_out), 32'(e.data));
        end
      end
    end
  end
  task automatic expect_rsp(input string n, input logic h, input logic [0:0] hw, input logic [0:0] vic,
                            input logic [4:0] tg, input logic [15:0] dt, input logic vl, input logic dy,
                            input logic ct, input logic cd);
    exp_t e;
    e = '{name: n, fl: 1'b0, hit: h, hw: hw, vic: vic, tag: tg, data: dt, vld: vl, dty: dy, ct: ct, cd: cd};
    q.push_back(e);
  endtask
  task automatic drain(input string n);
    for (int i = 0; i < 6; i++) begin
      if (q.size() == 0) return;
      @(posedge clk); #1;
    end
    chk({n, ".ack_timeout"}, 32'(q.size()), 32'd0);
    q.delete();
  endtask
  task automatic op(input string n, input logic c, input logic w, input logic [0:0] ws,
                    input logic [1:0] wd, input logic [4:0] tg, input logic [15:0] dt, input logic vi);
    @(posedge clk); #1;
    comp = c; write = w; way_sel = ws; word = wd; tag_in = tg; data_in = dt; valid_in = vi; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    drain(n);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not end, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    exp_t fe;
    rst_n = 1'b0; req = 1'b0; comp = 1'b0; write = 1'b0; way_sel = '0; word = '0;
    tag_in = '0; data_in = '0; valid_in = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst.ack", 32'(ack), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.hit", 32'(hit), 0);
    chk("rst.victim", 32'(victim_way), 0);
    chk("rst.valid", 32'(valid_out), 0);
    chk("rst.data", 32'(data_out), 0);
    expect_rsp("cmp_rd_empty", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    op("cmp_rd_empty", 1, 0, 0, 0, 5'h03, 0, 0);
    expect_rsp("acc_wr_w1", 0, 0, 0, 5'h0A, 16'hBEEF, 1, 0, 1, 1);
    op("acc_wr_w1", 0, 1, 1, 2, 5'h0A, 16'hBEEF, 1);
    expect_rsp("cmp_rd_hit", 1, 1, 0, 5'h0A, 16'hBEEF, 1, 0, 1, 1);
    op("cmp_rd_hit", 1, 0, 0, 2, 5'h0A, 0, 0);
    expect_rsp("cmp_wr_hit", 1, 1, 0, 5'h0A, 16'hBEEF, 1, 0, 1, 1);
    op("cmp_wr_hit", 1, 1, 0, 2, 5'h0A, 16'h1234, 0);
    expect_rsp("acc_rd_w1", 0, 0, 0, 5'h0A, 16'h1234, 1, 1, 1, 1);
    op("acc_rd_w1", 0, 0, 1, 2, 0, 0, 0);
    expect_rsp("fill_w0", 0, 0, 0, 5'h01, 16'h1111, 1, 0, 1, 1);
    op("fill_w0", 0, 1, 0, 0, 5'h01, 16'h1111, 1);
    expect_rsp("fill_w1", 0, 0, 1, 5'h02, 16'h2222, 1, 0, 1, 1);
    op("fill_w1", 0, 1, 1, 0, 5'h02, 16'h2222, 1);
    expect_rsp("touch_w0", 1, 0, 0, 5'h01, 16'h1111, 1, 0, 1, 1);
    op("touch_w0", 1, 0, 0, 0, 5'h01, 0, 0);
    expect_rsp("miss_lru", 0, 0, 1, 5'h02, 16'h2222, 1, 0, 1, 1);
    op("miss_lru", 1, 0, 0, 0, 5'h07, 0, 0);
    expect_rsp("cmp_wr_miss", 0, 0, 1, 5'h02, 16'h2222, 1, 0, 1, 1);
    op("cmp_wr_miss", 1, 1, 0, 0, 5'h07, 16'h9999, 0);
    expect_rsp("no_write_chk", 0, 0, 1, 5'h02, 16'h2222, 1, 0, 1, 1);
    op("no_write_chk", 0, 0, 1, 0, 0, 0, 0);
    expect_rsp("cmp_wr_w1", 1, 1, 1, 5'h02, 0, 1, 0, 1, 0);
    op("cmp_wr_w1", 1, 1, 0, 1, 5'h02, 16'hABCD, 0);
    expect_rsp("miss_w0_vic", 0, 0, 0, 5'h01, 16'h1111, 1, 0, 1, 1);
    op("miss_w0_vic", 1, 0, 0, 0, 5'h09, 0, 0);
    expect_rsp("acc_rd_dirty", 0, 0, 0, 5'h02, 16'hABCD, 1, 1, 1, 1);
    op("acc_rd_dirty", 0, 0, 1, 1, 0, 0, 0);
    fe = '{name: "flush", fl: 1'b1, hit: 0, hw: 0, vic: 0, tag: 0, data: 0, vld: 0, dty: 0, ct: 0, cd: 0};
    q.push_back(fe);
    @(posedge clk); #1;
    comp = 1; write = 1; way_sel = 0; word = 0; tag_in = 5'h02; data_in = 16'h5555; req = 1; flush = 1;
    @(posedge clk); #1;
    req = 0; flush = 0;
    n = 0;
    while (busy && n < 10) begin
      n++;
      @(posedge clk); #1;
    end
    chk("flush.busy_cycles", 32'(n), 32'd2);
    drain("flush");
    expect_rsp("post_flush_t2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    op("post_flush_t2", 1, 0, 0, 0, 5'h02, 0, 0);
    expect_rsp("post_flush_t1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    op("post_flush_t1", 1, 0, 0, 0, 5'h01, 0, 0);
    expect_rsp("flush_dropped_req", 0, 0, 0, 5'h02, 16'h2222, 0, 0, 1, 1);
    op("flush_dropped_req", 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    comp = 0; write = 1; way_sel = 0; word = 3; tag_in = 5'h0C; data_in = 16'h7777; valid_in = 1; req = 1;
    @(posedge clk); #1;
    req = 0; rst_n = 0;
    #2;
    chk("midrst.ack", 32'(ack), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.valid", 32'(valid_out), 0);
    @(posedge clk); #1 rst_n = 1;
    expect_rsp("after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    op("after_rst", 1, 0, 0, 3, 5'h0C, 0, 0);
    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
